fetch_predict_stage: RTL and testbench

FETCH_PREDICT_STAGE -- requirements
Module: fetch_predict_stage

---
 rtl/fetch_predict_stage_pkg.sv | 30 +++
 rtl/fetch_predict_stage_bht.sv | 37 +++
 rtl/fetch_predict_stage.sv | 99 +++++++++
 tb/tb_fetch_predict_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_predict_stage_pkg.sv
// Shared definitions for the fetch/predict stage: opcode and NOP constants,
// the 2-bit saturating branch counter type and its reset value, plus small
// helpers for counter update and RISC-V B-type immediate extraction.
package fetch_predict_stage_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = 2'b01;

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    bht_ctr_t r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'b01;
    end else begin
      if (c != 2'b00) r = c - 2'b01;
    end
    return r;
  endfunction

  // B-type immediate, sign-extended to 64 bits.
  function automatic logic [63:0] b_imm(input logic [31:0] i);
    return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predict_stage_bht.sv
// branch_history_table: array of 2-bit saturating counters.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset (all entries -> BHT_RESET)
//   rd_idx / rd_ctr   - combinational read port; returns the pre-update value
//                       when a write to the same entry happens this cycle
//   upd_en/upd_idx/upd_taken - saturating increment (taken) or decrement
module branch_history_table
  import fetch_predict_stage_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  bht_ctr_t ctr [DEPTH];

  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/fetch_predict_stage.sv
// fetch_predict_stage: PC register, branch prediction via a BHT, next-PC
// selection and the IF/ID pipeline register.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   stall                   - hold PC and IF/ID
//   Inst_Address            - current PC (registered, no input-to-output path)
//   Instruction             - instruction word for Inst_Address
//   ex_valid/ex_pc/ex_taken/ex_mispredict/ex_target - branch resolution from EX
//   ifid_valid/ifid_pc/ifid_instr/ifid_pred_taken   - IF/ID register outputs
module fetch_predict_stage
  import fetch_predict_stage_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 4,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic        ex_taken,
  input  logic        ex_mispredict,
  input  logic [63:0] ex_target,
  output logic        ifid_valid,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_pred_taken
);

  logic [63:0]          pc;
  logic [63:0]          pc_next;
  logic [63:0]          pred_pc;
  logic                 is_branch;
  logic                 pred_taken;
  logic                 redirect;
  bht_ctr_t             rd_ctr;
  logic [BHT_IDX_W-1:0] pc_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 unused_ex_pc_bits;

  assign pc_idx            = pc[BHT_IDX_W+1:2];
  assign ex_idx            = ex_pc[BHT_IDX_W+1:2];
  assign unused_ex_pc_bits = ^{ex_pc[63:BHT_IDX_W+2], ex_pc[1:0]};

  branch_history_table #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pc_idx),
    .rd_ctr   (rd_ctr),
    .upd_en   (ex_valid),
    .upd_idx  (ex_idx),
    .upd_taken(ex_taken)
  );

  assign Inst_Address = pc;
  assign redirect     = ex_valid && ex_mispredict;

  always_comb begin
    is_branch  = (Instruction[6:0] == OPC_BRANCH);
    pred_taken = is_branch && rd_ctr[1];
    pred_pc    = pred_taken ? (pc + b_imm(Instruction)) : (pc + 64'd4);
    if (redirect)   pc_next = ex_target;
    else if (stall) pc_next = pc;
    else            pc_next = pred_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Flush wins over stall so a redirect never leaves a stale instruction live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid      <= 1'b0;
      ifid_pc         <= '0;
      ifid_instr      <= NOP_INSTR;
      ifid_pred_taken <= 1'b0;
    end else if (redirect) begin
      ifid_valid      <= 1'b0;
      ifid_pc         <= '0;
      ifid_instr      <= NOP_INSTR;
      ifid_pred_taken <= 1'b0;
    end else if (!stall) begin
      ifid_valid      <= 1'b1;
      ifid_pc         <= pc;
      ifid_instr      <= Instruction;
      ifid_pred_taken <= pred_taken;
    end
  end

endmodule

// File: tb/tb_fetch_predict_stage.sv
module tb_fetch_predict_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ex_taken;
  logic        ex_mispredict;
  logic [63:0] ex_target;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_pred_taken;

  int checks;
  int failures;

  localparam logic [31:0] ADDI = 32'h00108093;
  localparam logic [31:0] BNE  = 32'hFE009CE3;
  localparam logic [31:0] NOP  = 32'h00000013;

  fetch_predict_stage #(
    .BHT_IDX_W(4),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .Inst_Address   (Inst_Address),
    .Instruction    (Instruction),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_mispredict  (ex_mispredict),
    .ex_target      (ex_target),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_pred_taken(ifid_pred_taken)
  );

  // Instruction memory: the branch lives at address 8, everything else is addi.
  assign Instruction = (Inst_Address == 64'd8) ? BNE : ADDI;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid      = 1'b0;
    ex_mispredict = 1'b0;
    ex_taken      = 1'b0;
    ex_pc         = 64'h0;
    ex_target     = 64'h0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    Inst_Address,          64'h0);
    chk({tag, "_valid"}, {63'd0, ifid_valid},   64'd0);
    chk({tag, "_ifpc"},  ifid_pc,               64'h0);
    chk({tag, "_instr"}, {32'd0, ifid_instr},   {32'd0, NOP});
    chk({tag, "_pred"},  {63'd0, ifid_pred_taken}, 64'd0);
  endtask

  // n cycles of BHT updates on entry 2 (ex_pc = 8), no redirect.
  task automatic train(input logic taken, input int n);
    for (int i = 0; i < n; i++) begin
      ex_valid = 1'b1; ex_pc = 64'd8; ex_taken = taken; ex_mispredict = 1'b0;
      step();
    end
    clear_ex();
  endtask

  // Redirect fetch to PC 8 (updating unrelated entry 0), then check the
  // prediction made for the branch there.
  task automatic probe8(input string tag, input logic exp_taken);
    ex_valid = 1'b1; ex_pc = 64'h100; ex_taken = 1'b0;
    ex_mispredict = 1'b1; ex_target = 64'd8;
    step();
    clear_ex();
    chk({tag, "_redir_pc"}, Inst_Address, 64'd8);
    step();
    chk({tag, "_next_pc"}, Inst_Address, exp_taken ? 64'd0 : 64'd12);
    chk({tag, "_pred"},    {63'd0, ifid_pred_taken}, {63'd0, exp_taken});
    chk({tag, "_ifpc"},    ifid_pc, 64'd8);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    stall = 1'b0;
    clear_ex();
    #2;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch
    step();
    chk("seq1_pc",    Inst_Address, 64'd4);
    chk("seq1_ifpc",  ifid_pc, 64'd0);
    chk("seq1_valid", {63'd0, ifid_valid}, 64'd1);
    chk("seq1_instr", {32'd0, ifid_instr}, {32'd0, ADDI});
    chk("seq1_pred",  {63'd0, ifid_pred_taken}, 64'd0);
    step();
    chk("seq2_pc",    Inst_Address, 64'd8);
    chk("seq2_ifpc",  ifid_pc, 64'd4);
    step();
    chk("br_nt_pc",    Inst_Address, 64'd12);
    chk("br_nt_ifpc",  ifid_pc, 64'd8);
    chk("br_nt_instr", {32'd0, ifid_instr}, {32'd0, BNE});
    chk("br_nt_pred",  {63'd0, ifid_pred_taken}, 64'd0);

    // Train entry 2: 01 -> 11
    train(1'b1, 2);
    probe8("trained", 1'b1);

    // Saturation: 11 +3 -> 11, then count down
    train(1'b1, 3);
    train(1'b0, 1);            // 10
    probe8("sat_hi", 1'b1);
    train(1'b0, 1);            // 01
    probe8("dn01", 1'b0);
    train(1'b0, 4);            // 00 (saturated)
    train(1'b1, 1);            // 01
    probe8("sat_lo", 1'b0);
    train(1'b1, 1);            // 10
    probe8("up10", 1'b1);
    train(1'b0, 1);            // 01

    // Same-entry read/update: prediction uses pre-update value (01)
    ex_valid = 1'b1; ex_pc = 64'h100; ex_mispredict = 1'b1; ex_target = 64'd8;
    step();
    ex_valid = 1'b1; ex_pc = 64'd8; ex_taken = 1'b1; ex_mispredict = 1'b0; ex_target = 64'd0;
    step();
    clear_ex();
    chk("bypass_pc",   Inst_Address, 64'd12);
    chk("bypass_pred", {63'd0, ifid_pred_taken}, 64'd0);
    probe8("post_bypass", 1'b1);   // counter now 10

    // Stall for 3 cycles: PC 0, IF/ID holds the predicted-taken branch
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc",    Inst_Address, 64'd0);
      chk("stall_ifpc",  ifid_pc, 64'd8);
      chk("stall_instr", {32'd0, ifid_instr}, {32'd0, BNE});
      chk("stall_pred",  {63'd0, ifid_pred_taken}, 64'd1);
      chk("stall_valid", {63'd0, ifid_valid}, 64'd1);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc",   Inst_Address, 64'd4);
    chk("unstall_ifpc", ifid_pc, 64'd0);
    chk("unstall_pred", {63'd0, ifid_pred_taken}, 64'd0);

    // Mispredict under stall
    stall = 1'b1;
    ex_valid = 1'b1; ex_pc = 64'h100; ex_mispredict = 1'b1; ex_target = 64'h40;
    step();
    stall = 1'b0;
    clear_ex();
    chk("flush_pc",    Inst_Address, 64'h40);
    chk("flush_valid", {63'd0, ifid_valid}, 64'd0);
    chk("flush_instr", {32'd0, ifid_instr}, {32'd0, NOP});

    // Mispredict without ex_valid is ignored
    ex_mispredict = 1'b1; ex_target = 64'h200;
    step();
    clear_ex();
    chk("ign_pc",    Inst_Address, 64'h44);
    chk("ign_valid", {63'd0, ifid_valid}, 64'd1);
    chk("ign_ifpc",  ifid_pc, 64'h40);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    step();
    chk_reset_vals("held");
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rel_ifpc",  ifid_pc, 64'd0);
    chk("rel_valid", {63'd0, ifid_valid}, 64'd1);
    chk("rel_pc",    Inst_Address, 64'd4);
    probe8("bht_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
